// File: rtl/fpu_pkg.sv
// Shared FPU definitions used by the mantissa multiplier, divider and normaliser.
// Holds significand/product widths, the iterative-unit FSM encoding and the
// helper that packs a full product into the integer/fraction/GRS layout.
package fpu_pkg;

    localparam int MANT_W = 24;               // significand width incl. hidden bit
    localparam int PROD_W = 28;               // 2 integer + 23 fraction + G/R/S
    localparam int GRS_W  = 3;                // guard, round, sticky
    localparam int CNT_W  = 5;                // iteration counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fpu_state_e;

    // Keep the top PROD_W-1 product bits and fold every discarded bit into sticky.
    function automatic logic [PROD_W-1:0] pack_product(input logic [2*MANT_W-1:0] p);
        return {p[2*MANT_W-1 -: PROD_W-1], |p[2*MANT_W-PROD_W:0]};
    endfunction

endpackage

// File: rtl/mantissa_multiplier_seq_if.sv
// Operand/result handshake bundle for the sequential mantissa multiplier.
// master = producer/consumer side, slave = the multiplier.
interface mantissa_multiplier_seq_if;
    import fpu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [MANT_W-1:0]   mant_a;
    logic [MANT_W-1:0]   mant_b;
    logic                out_valid;
    logic                out_ready;
    logic [PROD_W-1:0]   mant_product;
    logic                busy;

    modport master (
        output in_valid, mant_a, mant_b, out_ready,
        input  in_ready, out_valid, mant_product, busy
    );

    modport slave (
        input  in_valid, mant_a, mant_b, out_ready,
        output in_ready, out_valid, mant_product, busy
    );

endinterface

// File: rtl/mantissa_multiplier_seq.sv
// Iterative radix-2 shift-add multiplier for 24-bit significands.
// One operation in flight: IDLE accepts operands, BUSY runs 24 add/shift
// iterations, DONE holds the packed 28-bit product until the consumer takes it.
// Optional feature macro: MANT_MUL_ZERO_SKIP_EN -- a zero operand at acceptance
// finishes on the first BUSY edge with a zero product.
module mantissa_multiplier_seq #(
    parameter int MANT_W = fpu_pkg::MANT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    mantissa_multiplier_seq_if.slave bus
);
    import fpu_pkg::*;

    localparam int              ACC_W    = 2 * MANT_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MANT_W - 1);

    fpu_state_e          state_q;
    logic [MANT_W-1:0]   a_q;
    logic [MANT_W-1:0]   b_q;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [MANT_W:0]     add_sum;
    logic [ACC_W-1:0]    acc_next;
    logic                skip_now;

    assign bus.in_ready = (state_q == ST_IDLE);

    // One iteration: conditionally add the multiplicand into the upper 25 bits, then shift right.
    always_comb begin
        // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
        add_sum  = acc_q[ACC_W-1:MANT_W];
        acc_next = '0;
        if (b_q[0]) begin
            add_sum = acc_q[ACC_W-1:MANT_W] + {1'b0, a_q};
        end
        acc_next = {add_sum, acc_q[MANT_W-1:0]} >> 1;
    end

`ifdef MANT_MUL_ZERO_SKIP_EN
    logic zero_q;

    // Remember at acceptance whether either operand is zero so BUSY can finish at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (state_q == ST_IDLE && bus.in_valid) begin
            zero_q <= (bus.mant_a == '0) || (bus.mant_b == '0);
        end
    end

    assign skip_now = zero_q;
`else
    assign skip_now = 1'b0;
`endif

    // Control FSM with registered out_valid/busy/mant_product and the datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            bus.out_valid    <= 1'b0;
            bus.busy         <= 1'b0;
            bus.mant_product <= '0;
            a_q              <= '0;
            b_q              <= '0;
            acc_q            <= '0;
            cnt_q            <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.mant_a;
                        b_q      <= bus.mant_b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        bus.busy <= 1'b1;
                        state_q  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (skip_now) begin
                        bus.mant_product <= '0;
                        bus.out_valid    <= 1'b1;
                        bus.busy         <= 1'b0;
                        state_q          <= ST_DONE;
                    end else begin
                        acc_q <= acc_next;
                        b_q   <= b_q >> 1;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            bus.mant_product <= pack_product(acc_next[2*MANT_W-1:0]);
                            bus.out_valid    <= 1'b1;
                            bus.busy         <= 1'b0;
                            state_q          <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
